// File: rtl/and_gate_blk.sv
// and_gate_blk: bitwise 2-input AND with a registered copy and reduction flags.
// Optional feature macro: AND_GATE_STATS_EN adds a saturating hit_count of
// cycles where every bit of the AND result is set.
module and_gate_blk #(
    parameter int WIDTH = 1
`ifdef AND_GATE_STATS_EN
    ,
    parameter int CNT_WIDTH = 16
`endif
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic [WIDTH-1:0]     x,
    output logic [WIDTH-1:0]     x_q,
    output logic                 all_ones,
    output logic                 any_ones
`ifdef AND_GATE_STATS_EN
    ,
    output logic [CNT_WIDTH-1:0] hit_count
`endif
);

    logic [WIDTH-1:0] x_d;
    logic [WIDTH-1:0] x_reg_q;

    // Combinational AND and reduction flags; these ignore clock and reset so
    // X/Z on an input follows the native '&' semantics (0 & X = 0).
    always_comb begin
        x        = a & b;
        all_ones = &x;
        any_ones = |x;
        x_d      = a & b;
    end

    // Registered copy of the AND result; reset clears it without waiting for a clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_reg_q <= '0;
        end else begin
            x_reg_q <= x_d;
        end
    end

    assign x_q = x_reg_q;

`ifdef AND_GATE_STATS_EN
    logic [CNT_WIDTH-1:0] hit_count_d;
    logic [CNT_WIDTH-1:0] hit_count_q;

    // Next count: step on all_ones, but stick at the maximum rather than wrap.
    always_comb begin
        hit_count_d = hit_count_q;
        if (all_ones && (hit_count_q != {CNT_WIDTH{1'b1}})) begin
            hit_count_d = hit_count_q + 1'b1;
        end
    end

    // Hit counter register, cleared asynchronously by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_count_q <= '0;
        end else begin
            hit_count_q <= hit_count_d;
        end
    end

    assign hit_count = hit_count_q;
`endif

endmodule

// File: tb/tb_and_gate_blk.sv
// Directed testbench for and_gate_blk: one single-bit instance and one 8-bit
// instance (with a 2-bit hit counter when AND_GATE_STATS_EN is defined).
module tb_and_gate_blk;

    logic       clk;
    logic       rst;
    logic [0:0] a1;
    logic [0:0] b1;
    logic [0:0] x1;
    logic [0:0] xq1;
    logic       all1;
    logic       any1;
    logic [7:0] a8;
    logic [7:0] b8;
    logic [7:0] x8;
    logic [7:0] xq8;
    logic       all8;
    logic       any8;
`ifdef AND_GATE_STATS_EN
    logic [15:0] hc1;
    logic [1:0]  hc8;
`endif

    int testsRun;
    int testsFailed;

    and_gate_blk #(
        .WIDTH(1)
    ) u_dut1 (
        .clk      (clk),
        .rst      (rst),
        .a        (a1),
        .b        (b1),
        .x        (x1),
        .x_q      (xq1),
        .all_ones (all1),
        .any_ones (any1)
`ifdef AND_GATE_STATS_EN
        ,
        .hit_count(hc1)
`endif
    );

    and_gate_blk #(
        .WIDTH(8)
`ifdef AND_GATE_STATS_EN
        ,
        .CNT_WIDTH(2)
`endif
    ) u_dut8 (
        .clk      (clk),
        .rst      (rst),
        .a        (a8),
        .b        (b8),
        .x        (x8),
        .x_q      (xq8),
        .all_ones (all8),
        .any_ones (any8)
`ifdef AND_GATE_STATS_EN
        ,
        .hit_count(hc8)
`endif
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single point of comparison: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    // Drives both operand pairs in one step.
    task automatic applyStimulus(input logic [0:0] na1, input logic [0:0] nb1,
                                 input logic [7:0] na8, input logic [7:0] nb8);
        a1 = na1;
        b1 = nb1;
        a8 = na8;
        b8 = nb8;
    endtask

    logic [1:0]  tt_in  [4];
    logic        tt_out [4];
    logic [1:0]  hc_exp [5];

    initial begin
        testsRun    = 0;
        testsFailed = 0;
        tt_in[0] = 2'b00; tt_out[0] = 1'b0;
        tt_in[1] = 2'b01; tt_out[1] = 1'b0;
        tt_in[2] = 2'b10; tt_out[2] = 1'b0;
        tt_in[3] = 2'b11; tt_out[3] = 1'b1;
        hc_exp[0] = 2'd1; hc_exp[1] = 2'd2; hc_exp[2] = 2'd3;
        hc_exp[3] = 2'd3; hc_exp[4] = 2'd3;

        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 8'h00, 8'h00);
        #2;
        checkOutput("reset_xq1", {31'b0, xq1}, 32'h0);
        checkOutput("reset_xq8", {24'b0, xq8}, 32'h0);
`ifdef AND_GATE_STATS_EN
        checkOutput("reset_hc8", {30'b0, hc8}, 32'h0);
`endif

        // Truth table, held in reset so no register captures anything.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(tt_in[i][1], tt_in[i][0], 8'h00, 8'h00);
            #10;
            checkOutput($sformatf("tt_x_%0d", i), {31'b0, x1}, {31'b0, tt_out[i]});
            checkOutput($sformatf("tt_all_%0d", i), {31'b0, all1}, {31'b0, tt_out[i]});
            checkOutput($sformatf("tt_any_%0d", i), {31'b0, any1}, {31'b0, tt_out[i]});
            checkOutput($sformatf("tt_xq_inrst_%0d", i), {31'b0, xq1}, 32'h0);
        end

        // 8-bit combinational vectors.
        applyStimulus(1'b0, 1'b0, 8'hF0, 8'h3C);
        #1;
        checkOutput("w8_x_f0_3c", {24'b0, x8}, 32'h30);
        checkOutput("w8_all_f0_3c", {31'b0, all8}, 32'h0);
        checkOutput("w8_any_f0_3c", {31'b0, any8}, 32'h1);
        applyStimulus(1'b0, 1'b0, 8'hFF, 8'hFF);
        #1;
        checkOutput("w8_x_ff", {24'b0, x8}, 32'hFF);
        checkOutput("w8_all_ff", {31'b0, all8}, 32'h1);
        checkOutput("w8_any_ff", {31'b0, any8}, 32'h1);
        applyStimulus(1'b0, 1'b0, 8'hA5, 8'h5A);
        #1;
        checkOutput("w8_x_a5_5a", {24'b0, x8}, 32'h00);
        checkOutput("w8_any_a5_5a", {31'b0, any8}, 32'h0);
        applyStimulus(1'b0, 1'b0, 8'h7F, 8'hFF);
        #1;
        checkOutput("w8_all_7f", {31'b0, all8}, 32'h0);
        checkOutput("w8_any_7f", {31'b0, any8}, 32'h1);

        // Release reset and check registered capture latency.
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 8'hF0, 8'h3C);
        rst = 1'b0;
        #1;
        checkOutput("xq8_before_edge", {24'b0, xq8}, 32'h0);
        @(posedge clk);
        #1;
        checkOutput("xq8_first_capture", {24'b0, xq8}, 32'h30);
        applyStimulus(1'b0, 1'b0, 8'hC3, 8'h0F);
        #1;
        checkOutput("x8_same_cycle", {24'b0, x8}, 32'h03);
        checkOutput("xq8_holds", {24'b0, xq8}, 32'h30);
        @(posedge clk);
        #1;
        checkOutput("xq8_next_edge", {24'b0, xq8}, 32'h03);

        // Asynchronous reset pulse mid-cycle with a=b=1.
        applyStimulus(1'b1, 1'b1, 8'h00, 8'h00);
        @(posedge clk);
        #1;
        checkOutput("xq1_before_pulse", {31'b0, xq1}, 32'h1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("xq1_async_clear", {31'b0, xq1}, 32'h0);
        checkOutput("x1_during_rst", {31'b0, x1}, 32'h1);
        checkOutput("all1_during_rst", {31'b0, all1}, 32'h1);
        rst = 1'b0;
        #1;
        checkOutput("xq1_after_rst_no_edge", {31'b0, xq1}, 32'h0);
        @(posedge clk);
        #1;
        checkOutput("xq1_after_rst_edge", {31'b0, xq1}, 32'h1);

        // a rises 0->1 with b=1: x immediate, x_q on the next edge.
        applyStimulus(1'b0, 1'b1, 8'h00, 8'h00);
        @(posedge clk);
        #1;
        checkOutput("xq1_low", {31'b0, xq1}, 32'h0);
        @(negedge clk);
        a1 = 1'b1;
        #1;
        checkOutput("x1_rise", {31'b0, x1}, 32'h1);
        checkOutput("xq1_not_yet", {31'b0, xq1}, 32'h0);
        @(posedge clk);
        #1;
        checkOutput("xq1_rise", {31'b0, xq1}, 32'h1);

`ifdef AND_GATE_STATS_EN
        // Saturating hit counter on the 2-bit instance.
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 8'h00, 8'h00);
        rst = 1'b1;
        #1;
        checkOutput("hc8_cleared", {30'b0, hc8}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(1'b0, 1'b0, 8'hFF, 8'hFF);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            checkOutput($sformatf("hc8_cycle_%0d", i), {30'b0, hc8}, {30'b0, hc_exp[i]});
        end
        #1;
        rst = 1'b1;
        #1;
        checkOutput("hc8_async_clear", {30'b0, hc8}, 32'h0);
        rst = 1'b0;
`endif

        // X on one input: a zero on the other input still forces x to 0.
        applyStimulus(1'b0, 1'bx, 8'h00, 8'h00);
        #1;
        checkOutput("x1_zero_and_x", {31'b0, x1}, 32'h0);
        checkOutput("any1_zero_and_x", {31'b0, any1}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
